// File: rtl/avalon_ingress_queues_pkg.sv
// Shared address map constants and helpers for the Avalon ingress queue block.
package ingress_pkg;

  localparam int ADDR_STATUS    = 0;
  localparam int ADDR_CH_BASE   = 1;
  localparam int ADDR_DROP_BASE = 8;
  localparam int DROP_W         = 16;

  // Channel index addressed by a word address relative to a window base; negative means below it.
  function automatic int ch_of_addr(input int addr, input int base);
    return addr - base;
  endfunction

endpackage

// File: rtl/avalon_ingress_queues_fifo.sv
// One first-word-fall-through channel FIFO; a simultaneous read frees a slot for a write when full.
module ingress_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rd_fire, wr_fire;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rd_fire = rd_en_i && !empty_o;
  assign wr_fire = wr_en_i && (!full_o || rd_fire);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_fire) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_fire, rd_fire})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Head is forced to zero when empty so the port is clean out of reset.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/avalon_ingress_queues.sv
// Avalon-MM ingress: per-channel enqueue FIFOs, status/occupancy reads, flush.
// Optional per-channel saturating drop counters when DROP_CNT_EN is defined.
module avalon_ingress_queues
  import ingress_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     chipselect,
  input  logic                     write,
  input  logic                     read,
  input  logic [ADDR_W-1:0]        address,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0][DATA_W-1:0] head;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0]             full, empty, wr_en, flush;
  logic                          cs_wr, cs_rd;
  logic [31:0]                   rdata_d, readdata_q;
  logic [7:0]                    full8, empty8;

  assign cs_wr = chipselect && write;
  assign cs_rd = chipselect && read;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_en[g] = cs_wr && (ch_of_addr(int'(address), ADDR_CH_BASE) == g);
    assign flush[g] = cs_wr && (address == ADDR_W'(ADDR_STATUS)) && writedata[g];

    ingress_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_en[g]),
      .rd_en_i   (out_ready[g]),
      .flush_i   (flush[g]),
      .wr_data_i (writedata[DATA_W-1:0]),
      .rd_data_o (head[g]),
      .count_o   (cnt[g]),
      .full_o    (full[g]),
      .empty_o   (empty[g])
    );
  end

  assign out_valid = ~empty;
  assign out_data  = head;

`ifdef DROP_CNT_EN
  logic [NUM_CH-1:0][DROP_W-1:0] drop_q;

  // A write to a full channel is only lost if the head is not leaving in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush[c])
          drop_q[c] <= '0;
        else if (wr_en[c] && full[c] && !out_ready[c] && (drop_q[c] != '1))
          drop_q[c] <= drop_q[c] + DROP_W'(1);
      end
    end
  end
`endif

  always_comb begin
    rdata_d = '0;
    full8   = '0;
    empty8  = '0;
    full8[NUM_CH-1:0]  = full;
    empty8[NUM_CH-1:0] = empty;
    if (address == ADDR_W'(ADDR_STATUS)) rdata_d = {16'b0, full8, empty8};
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(address) == ADDR_CH_BASE + c) rdata_d = 32'(cnt[c]);
`ifdef DROP_CNT_EN
      if (int'(address) == ADDR_DROP_BASE + c) rdata_d = 32'(drop_q[c]);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     readdata_q <= '0;
    else if (cs_rd) readdata_q <= rdata_d;
  end

  assign readdata = readdata_q;

endmodule
